// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the 16-bit CPU datapath.
// Gates PC advance, instruction latch and register write; run/step/halt control.
module cpu_seq_ctrl #(
    parameter int         INST_W  = 16,
    parameter int         CNT_W   = 16,
    parameter logic [6:0] OP_NOP  = 7'h00,
    parameter logic [6:0] OP_ADD  = 7'h01,
    parameter logic [6:0] OP_SUB  = 7'h02,
    parameter logic [6:0] OP_HALT = 7'h7F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              halt_req,
    input  logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] ir,
    output logic              pc_en,
    output logic              rf_we,
    output logic              alu_op,
    output logic              running,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                mode_step_q, mode_step_d;
    logic                halt_pend_q, halt_pend_d;
    logic                illegal_q, illegal_d;
    logic                pc_en_q, pc_en_d;
    logic                rf_we_q, rf_we_d;
    logic                alu_op_q;
    logic [INST_W-1:0]   ir_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [6:0]          ir_op;
    logic [6:0]          inst_op;
    logic                busy;

    assign ir_op   = ir_q[INST_W-1:INST_W-7];
    assign inst_op = inst[INST_W-1:INST_W-7];
    assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXEC)  || (state_q == S_WB);

    always_comb begin
        state_d     = state_q;
        mode_step_d = mode_step_q;
        halt_pend_d = halt_pend_q;
        illegal_d   = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_FETCH;
                    mode_step_d = 1'b0;
                end else if (step) begin
                    state_d     = S_FETCH;
                    mode_step_d = 1'b1;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (ir_op == OP_ADD || ir_op == OP_SUB) begin
                    state_d = S_EXEC;
                end else if (ir_op == OP_NOP) begin
                    state_d = S_WB;
                end else if (ir_op == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d   = S_HALTED;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                // a halt_req arriving in the WB cycle itself still stops here
                if (mode_step_q || halt_pend_q || halt_req) state_d = S_IDLE;
                else                                        state_d = S_FETCH;
            end
            S_HALTED: begin
                if (start) begin
                    state_d     = S_FETCH;
                    mode_step_d = 1'b0;
                    illegal_d   = 1'b0;
                end else if (step) begin
                    state_d     = S_FETCH;
                    mode_step_d = 1'b1;
                    illegal_d   = 1'b0;
                end
            end
            default:  state_d = S_IDLE;
        endcase

        if (busy && halt_req) halt_pend_d = 1'b1;
        if (state_d == S_IDLE || state_d == S_HALTED) halt_pend_d = 1'b0;

        // Strobes are registered: look one state ahead so they line up with WB,
        // and with DECODE for a HALT seen on the fetch bus.
        rf_we_d = (state_q == S_EXEC) && (state_d == S_WB);
        pc_en_d = (state_d == S_WB) ||
                  ((state_q == S_FETCH) && (inst_op == OP_HALT));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mode_step_q <= 1'b0;
            halt_pend_q <= 1'b0;
            illegal_q   <= 1'b0;
            pc_en_q     <= 1'b0;
            rf_we_q     <= 1'b0;
            alu_op_q    <= 1'b0;
            ir_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_step_q <= mode_step_d;
            halt_pend_q <= halt_pend_d;
            illegal_q   <= illegal_d;
            pc_en_q     <= pc_en_d;
            rf_we_q     <= rf_we_d;
            if (state_q == S_FETCH)  ir_q     <= inst;
            if (state_q == S_DECODE) alu_op_q <= (ir_op == OP_SUB);
            if (state_q == S_WB)     cnt_q    <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ir          = ir_q;
    assign pc_en       = pc_en_q;
    assign rf_we       = rf_we_q;
    assign alu_op      = alu_op_q;
    assign running     = busy;
    assign halted      = (state_q == S_HALTED);
    assign illegal     = illegal_q;
    assign retired_cnt = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomized bench for cpu_seq_ctrl against an instruction-level reference model.
// Counter width is narrowed so the retired-count wrap is reachable in a short run.
module tb_cpu_seq_ctrl;

    localparam int         INST_W  = 16;
    localparam int         CNT_W   = 8;
    localparam logic [6:0] OP_NOP  = 7'h00;
    localparam logic [6:0] OP_ADD  = 7'h01;
    localparam logic [6:0] OP_SUB  = 7'h02;
    localparam logic [6:0] OP_HALT = 7'h7F;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              step = 1'b0;
    logic              halt_req = 1'b0;
    logic [INST_W-1:0] inst = '0;
    logic [INST_W-1:0] ir;
    logic              pc_en, rf_we, alu_op, running, halted, illegal;
    logic [CNT_W-1:0]  retired_cnt;
    logic [2:0]        state;

    cpu_seq_ctrl #(
        .INST_W(INST_W), .CNT_W(CNT_W),
        .OP_NOP(OP_NOP), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB), .OP_HALT(OP_HALT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .step(step), .halt_req(halt_req),
        .inst(inst), .ir(ir), .pc_en(pc_en), .rf_we(rf_we), .alu_op(alu_op),
        .running(running), .halted(halted), .illegal(illegal),
        .retired_cnt(retired_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural state only, updated once per instruction.
    int exp_cnt   = 0;
    bit m_step    = 1'b0;
    bit m_pend    = 1'b0;
    bit m_illegal = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit use_start, input bit use_step);
        start = use_start;
        step  = use_step;
        tick();
        start = 1'b0;
        step  = 1'b0;
        m_step    = !use_start;
        m_pend    = 1'b0;
        m_illegal = 1'b0;
        chk("launch_state", 32'(state), 32'd1);
        chk("launch_halted", 32'(halted), 32'd0);
        chk("launch_running", 32'(running), 32'd1);
        chk("launch_illegal", 32'(illegal), 32'd0);
    endtask

    task automatic idle_wait(input int n, input logic [2:0] exp_state);
        for (int i = 0; i < n; i++) begin
            halt_req = 1'($urandom_range(0, 1));
            tick();
            halt_req = 1'b0;
            chk("wait_state", 32'(state), 32'(exp_state));
            chk("wait_halted", 32'(halted), 32'(exp_state == 3'd5));
            chk("wait_running", 32'(running), 32'd0);
            chk("wait_pc_en", 32'(pc_en), 32'd0);
            chk("wait_rf_we", 32'(rf_we), 32'd0);
        end
    endtask

    // Executes one instruction starting in FETCH; returns the state that follows.
    task automatic do_instr(input logic [15:0] instr, input int halt_at,
                            input bit noise, output logic [2:0] nxt);
        logic [6:0] op;
        int         kind;
        int         seq[$];
        op = instr[15:9];
        if (op == OP_ADD || op == OP_SUB) begin
            kind = 0; seq = '{1, 2, 3, 4};
        end else if (op == OP_NOP) begin
            kind = 1; seq = '{1, 2, 4};
        end else if (op == OP_HALT) begin
            kind = 2; seq = '{1, 2};
        end else begin
            kind = 3; seq = '{1, 2};
        end
        inst = instr;
        for (int k = 0; k < seq.size(); k++) begin
            chk("seq_state", 32'(state), 32'(seq[k]));
            chk("seq_running", 32'(running), 32'd1);
            chk("seq_pc_en", 32'(pc_en), 32'((seq[k] == 4) || (seq[k] == 2 && kind == 2)));
            chk("seq_rf_we", 32'(rf_we), 32'(seq[k] == 4 && kind == 0));
            if (seq[k] == 2) chk("seq_ir", 32'(ir), 32'(instr));
            if (seq[k] >= 3 && kind == 0) chk("seq_alu_op", 32'(alu_op), 32'(op == OP_SUB));
            if (k == halt_at) begin
                halt_req = 1'b1;
                m_pend   = 1'b1;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                step  = 1'($urandom_range(0, 1));
            end
            tick();
            halt_req = 1'b0;
            start    = 1'b0;
            step     = 1'b0;
            if (k == 0) inst = 16'($urandom);
        end
        if (kind >= 2) begin
            nxt       = 3'd5;
            m_pend    = 1'b0;
            m_illegal = (kind == 3);
        end else begin
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            nxt     = (m_step || m_pend) ? 3'd0 : 3'd1;
            if (nxt == 3'd0) m_pend = 1'b0;
        end
        chk("end_state", 32'(state), 32'(nxt));
        chk("end_illegal", 32'(illegal), 32'(m_illegal));
        chk("end_halted", 32'(halted), 32'(nxt == 3'd5));
        chk("end_retired", 32'(retired_cnt), 32'(exp_cnt));
        chk("end_rf_we", 32'(rf_we), 32'd0);
        chk("end_pc_en", 32'(pc_en), 32'd0);
    endtask

    function automatic logic [15:0] mk(input logic [6:0] op);
        return {op, 9'($urandom)};
    endfunction

    logic [2:0]  nxt;
    logic [15:0] rnd_inst;
    int          sel;

    initial begin
        // Reset held for two cycles
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_retired", 32'(retired_cnt), 32'd0);
        rst = 1'b1;
        idle_wait(2, 3'd0);

        // Single step of ADD r0,r2->r1
        launch(1'b0, 1'b1);
        do_instr(16'h0211, -1, 1'b0, nxt);

        // Continuous run SUB, NOP, SUB with halt_req in the last EXEC
        launch(1'b1, 1'b0);
        do_instr({OP_SUB, 9'h0A3}, -1, 1'b0, nxt);
        do_instr({OP_NOP, 9'h000}, -1, 1'b0, nxt);
        do_instr({OP_SUB, 9'h1C5}, 2, 1'b0, nxt);
        idle_wait(1, 3'd0);

        // HALT instruction, then restart out of HALTED
        launch(1'b1, 1'b0);
        do_instr(16'hFE00, -1, 1'b0, nxt);
        idle_wait(2, 3'd5);
        launch(1'b1, 1'b0);
        do_instr({OP_ADD, 9'h012}, 3, 1'b0, nxt);

        // Illegal opcode, cleared by step
        launch(1'b1, 1'b0);
        do_instr({7'h55, 9'h000}, -1, 1'b0, nxt);
        idle_wait(2, 3'd5);
        launch(1'b0, 1'b1);
        do_instr({OP_NOP, 9'h1FF}, -1, 1'b0, nxt);

        // Reset during EXEC aborts the ADD
        launch(1'b1, 1'b0);
        inst = {OP_ADD, 9'h049};
        tick();
        tick();
        chk("mid_exec_state", 32'(state), 32'd3);
        rst = 1'b0;
        tick();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_rf_we", 32'(rf_we), 32'd0);
        chk("abort_pc_en", 32'(pc_en), 32'd0);
        chk("abort_retired", 32'(retired_cnt), 32'd0);
        rst = 1'b1;
        exp_cnt = 0;
        m_pend  = 1'b0;

        // Retired counter wrap: all-ones, then one more ADD
        launch(1'b1, 1'b0);
        for (int i = 0; i < (1 << CNT_W) - 1; i++) do_instr({OP_NOP, 9'h000}, -1, 1'b0, nxt);
        do_instr({OP_ADD, 9'h0AA}, 0, 1'b0, nxt);
        chk("wrap_retired", 32'(retired_cnt), 32'd0);

        // Randomized instruction stream with halts, illegal ops and input noise
        launch(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 6)       rnd_inst = mk(OP_ADD);
            else if (sel < 12) rnd_inst = mk(OP_SUB);
            else if (sel < 17) rnd_inst = mk(OP_NOP);
            else if (sel < 18) rnd_inst = mk(OP_HALT);
            else               rnd_inst = mk(7'($urandom_range(3, 126)));
            do_instr(rnd_inst, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
                     1'b1, nxt);
            if (nxt != 3'd1) begin
                idle_wait(int'($urandom_range(0, 3)), nxt);
                sel = int'($urandom_range(0, 2));
                launch(sel != 1, sel != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
